// File: rtl/simd_regfile_sb.sv
// Unified scalar/vector SIMD register file with per-lane write mask, sequenced
// post-reset clear and per-register busy scoreboard. Optional forwarding: RF_BYPASS_EN.
module simd_regfile_sb #(
   parameter int XLEN   = 32,
   parameter int LANES  = 4,
   parameter int ADDR_W = 5
) (
   input  logic                    clk,
   input  logic                    rst,
   output logic                    ready,
   input  logic [ADDR_W-1:0]       a1,
   input  logic [ADDR_W-1:0]       a2,
   output logic [LANES*XLEN-1:0]   rd1,
   output logic [LANES*XLEN-1:0]   rd2,
   input  logic                    we3,
   input  logic [ADDR_W-1:0]       a3,
   input  logic [LANES*XLEN-1:0]   wd3,
   input  logic [LANES-1:0]        wmask3,
   input  logic                    rsv_en,
   input  logic [ADDR_W-1:0]       rsv_addr,
   output logic                    busy1,
   output logic                    busy2
);
   localparam int DW    = LANES * XLEN;
   localparam int NVREG = 2 ** (ADDR_W - 2);
   localparam int NSREG = 3 * NVREG;
   localparam int VI_W  = ADDR_W - 2;
   localparam int NADDR = 2 ** ADDR_W;

   typedef enum logic [0:0] {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic [NADDR-1:0]    busy_q, busy_d;
   logic [XLEN-1:0]     scalar_q [NSREG];
   logic [DW-1:0]       vector_q [NVREG];

   logic                ready_s, clr_s, wr_ok_s;
   logic                s_we_s, v_we_s;
   logic [ADDR_W-1:0]   s_idx_s;
   logic [VI_W-1:0]     v_idx_s;
   logic [XLEN-1:0]     s_wdata_s;
   logic [DW-1:0]       v_wdata_s;
   logic [LANES-1:0]    v_lane_en_s;
   logic [DW-1:0]       rd1_s, rd2_s;

   function automatic logic is_vec(input logic [ADDR_W-1:0] a);
      return a[ADDR_W-1 -: 2] == 2'b11;
   endfunction

   function automatic logic [DW-1:0] bcast(input logic [XLEN-1:0] v);
      logic [DW-1:0] r;
      for (int l = 0; l < LANES; l++) r[l*XLEN +: XLEN] = v;
      return r;
   endfunction

   function automatic logic [DW-1:0] stored_val(input logic [ADDR_W-1:0] a);
      if (a == {ADDR_W{1'b0}}) return {DW{1'b0}};
      else if (is_vec(a))      return vector_q[a[VI_W-1:0]];
      else                     return bcast(scalar_q[a]);
   endfunction

`ifdef RF_BYPASS_EN
   // Post-write view of a register while a write to it is in flight.
   function automatic logic [DW-1:0] merge_write(input logic [ADDR_W-1:0] a,
                                                 input logic [DW-1:0]     stored);
      logic [DW-1:0] v;
      v = stored;
      if (is_vec(a)) begin
         for (int l = 0; l < LANES; l++) begin
            if (wmask3[l]) v[l*XLEN +: XLEN] = wd3[l*XLEN +: XLEN];
            else           v[l*XLEN +: XLEN] = stored[l*XLEN +: XLEN];
         end
      end else if (wmask3[0]) begin
         v = bcast(wd3[XLEN-1:0]);
      end else begin
         v = stored;
      end
      return v;
   endfunction
`endif

   function automatic logic [DW-1:0] port_read(input logic [ADDR_W-1:0] a);
      logic [DW-1:0] v;
      v = stored_val(a);
`ifdef RF_BYPASS_EN
      if (we3 && ready_s && (a3 != {ADDR_W{1'b0}}) && (a3 == a)) v = merge_write(a, v);
      else                                                       v = stored_val(a);
`endif
      return v;
   endfunction

   assign ready_s = (state_q == ST_RUN);
   assign ready   = ready_s;
   assign rd1     = rd1_s;
   assign rd2     = rd2_s;
   assign busy1   = ready_s & busy_q[a1];
   assign busy2   = ready_s & busy_q[a2];

   // Clear sequencer next state: walk cnt over the scalar index space after reset.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      clr_s   = 1'b0;
      if (rst) begin
         state_d = ST_CLEAR;
         cnt_d   = {ADDR_W{1'b0}};
      end else begin
         case (state_q)
            ST_CLEAR: begin
               clr_s = 1'b1;
               if (cnt_q == ADDR_W'(NSREG - 1)) begin
                  state_d = ST_RUN;
                  cnt_d   = {ADDR_W{1'b0}};
               end else begin
                  cnt_d = cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
               end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_CLEAR;
         endcase
      end
   end

   // Storage write port: clear sequencer has priority, otherwise the masked user write.
   always_comb begin
      wr_ok_s     = we3 && ready_s && !rst && (a3 != {ADDR_W{1'b0}});
      s_we_s      = 1'b0;
      s_idx_s     = cnt_q;
      s_wdata_s   = {XLEN{1'b0}};
      v_we_s      = 1'b0;
      v_idx_s     = cnt_q[VI_W-1:0];
      v_lane_en_s = {LANES{1'b0}};
      v_wdata_s   = {DW{1'b0}};
      if (clr_s) begin
         s_we_s      = 1'b1;
         v_we_s      = (cnt_q < ADDR_W'(NVREG));
         v_lane_en_s = {LANES{1'b1}};
      end else if (wr_ok_s) begin
         if (is_vec(a3)) begin
            v_we_s      = 1'b1;
            v_idx_s     = a3[VI_W-1:0];
            v_lane_en_s = wmask3;
            v_wdata_s   = wd3;
         end else begin
            s_we_s    = wmask3[0];
            s_idx_s   = a3;
            s_wdata_s = wd3[XLEN-1:0];
         end
      end else begin
         s_we_s = 1'b0;
      end
   end

   // Scoreboard next state: write clears, reserve sets afterwards so it wins.
   always_comb begin
      busy_d = busy_q;
      if (rst) begin
         busy_d = {NADDR{1'b0}};
      end else if (ready_s) begin
         if (we3)    busy_d[a3]       = 1'b0;
         else        busy_d           = busy_q;
         if (rsv_en) busy_d[rsv_addr] = 1'b1;
         else        busy_d[0]        = 1'b0;
      end else begin
         busy_d = busy_q;
      end
      busy_d[0] = 1'b0;
   end

   // Read ports, gated to zero until the clear sequence has finished.
   always_comb begin
      rd1_s = {DW{1'b0}};
      rd2_s = {DW{1'b0}};
      if (ready_s) begin
         rd1_s = port_read(a1);
         rd2_s = port_read(a2);
      end else begin
         rd1_s = {DW{1'b0}};
         rd2_s = {DW{1'b0}};
      end
   end

   // Control state registers.
   always_ff @(posedge clk) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
   end

   // Register storage, no reset so it can map onto RAM.
   always_ff @(posedge clk) begin
      if (s_we_s) scalar_q[s_idx_s] <= s_wdata_s;
      if (v_we_s) begin
         for (int l = 0; l < LANES; l++) begin
            if (v_lane_en_s[l]) vector_q[v_idx_s][l*XLEN +: XLEN] <= v_wdata_s[l*XLEN +: XLEN];
         end
      end
   end
endmodule

// File: doc/simd_regfile_sb.md
Name: simd_regfile_sb

Overview:
- Parametrised successor to the scalar/vector register file, for the SIMD core datapath.
- Unified address space: register 0 reads as zero, a band of scalar registers, and a band of LANES-wide vector registers.
- Adds per-lane write masking and a sequenced post-reset clear, so storage can map to RAM.
- Adds a per-register busy scoreboard for the issue stage, plus optional write-to-read forwarding.

Parameters:
- XLEN, 32, width of one scalar register and one vector lane.
- LANES, 4, lanes per vector register; the data bus is LANES*XLEN bits.
- ADDR_W, 5, register address width.
- Derived NVREG = 2**(ADDR_W-2): number of vector registers.
- Derived NSREG = 3*NVREG: scalar index space; index 0 is hardwired zero.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- ready  out  1  high when the clear sequence is done and the file accepts traffic.
- a1  in  ADDR_W  read port 1 address.
- a2  in  ADDR_W  read port 2 address.
- rd1  out  LANES*XLEN  read port 1 data.
- rd2  out  LANES*XLEN  read port 2 data.
- we3  in  1  write enable.
- a3  in  ADDR_W  write address.
- wd3  in  LANES*XLEN  write data.
- wmask3  in  LANES  per-lane write mask; bit i enables lane i, bits [i*XLEN +: XLEN].
- rsv_en  in  1  reserve strobe: mark rsv_addr busy.
- rsv_addr  in  ADDR_W  register to reserve.
- busy1  out  1  scoreboard bit for a1.
- busy2  out  1  scoreboard bit for a2.

Behaviour:
- Address decode:
  - a[ADDR_W-1:ADDR_W-2]==2'b11 selects vector register a[ADDR_W-3:0].
  - Otherwise the address selects scalar register a; address 0 is always zero.
- Reads are combinational.
  - Vector read returns the full register.
  - Scalar read returns the scalar replicated LANES times.
  - Address 0 returns all zeros.
  - rd1, rd2 and busy1/busy2 are forced to 0 while ready=0.
- Writes take effect on the rising edge when we3=1 and ready=1.
  - Vector write: lane i is updated only if wmask3[i]=1.
  - Scalar write: takes wd3[XLEN-1:0] and occurs only if wmask3[0]=1.
  - Writes to address 0 are discarded.
- State machine, 2 states:
  - CLEAR: ready=0, counter cnt.
    - While rst=1: stay in CLEAR, cnt=0, all busy bits cleared.
    - Each cycle with rst=0: zero scalar[cnt]; zero vector[cnt] if cnt<NVREG; then cnt++.
    - When cnt==NSREG-1 is cleared, go to RUN.
    - ready rises exactly NSREG cycles after the first edge with rst=0 (default 24).
  - RUN: ready=1. rst=1 at any edge returns to CLEAR with cnt=0; a write or reserve in that cycle is dropped.
- Scoreboard:
  - One busy bit per address, 2**ADDR_W bits.
  - rsv_en=1 with ready=1 sets busy[rsv_addr].
  - A completed write (we3=1, ready=1) clears busy[a3], regardless of mask.
  - Reserve and write to the same address in the same cycle: busy ends at 1 (reserve wins).
  - busy[0] reads as 0 permanently.
  - busy1/busy2 show registered state only; a same-cycle reserve is not forwarded.
- Reset values:
  - ready=0; all storage zero once ready=1; all busy bits 0.
  - rd1/rd2=0 while ready=0.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: when we3=1, ready=1, a3!=0 and a3==a1, rd1 returns the post-write value combinationally in the same cycle; likewise for a2/rd2.
  - Vector: masked lanes come from wd3, unmasked lanes from storage.
  - Scalar: replicated wd3[XLEN-1:0] if wmask3[0]=1, else the stored value.
- Not defined: reads return pre-write storage contents; new data is visible from the next cycle.

Test Plan:
- Reset clear: assert rst 2 cycles, release -> ready=0 for 24 cycles then 1; read every address -> 0; busy1=busy2=0.
- Vector masked write: write a3=5'b11010 with wd3=128'hDDDD_CCCC_BBBB_AAAA_..., wmask3=4'b0101 over a register pre-filled with 128'h1111...; read a1=5'b11010 -> lanes 0 and 2 new, lanes 1 and 3 still 32'h11111111.
- Scalar write and broadcast:
  - Write a3=7, wd3 low word 32'h12345678, wmask3=4'b0001; then a1=7 -> rd1=128'h12345678_12345678_12345678_12345678.
  - Same write with wmask3[0]=0 -> value unchanged.
  - Write to a3=0 -> a1=0 still reads 0.
- Scoreboard:
  - rsv_en on addr 9 -> next cycle busy1=1 with a1=9.
  - Write to 9 -> busy clears the following cycle.
  - rsv_en and we3 both on addr 9 in the same cycle -> busy stays 1.
- Bypass, with and without RF_BYPASS_EN: write a3=a1=3 with 32'hCAFE0001 over old 32'h0BAD0000 -> rd1 same cycle = replicated CAFE0001 if defined, 0BAD0000 if not; next cycle CAFE0001 in both builds.
- Reset mid-operation:
  - In RUN, assert rst together with we3 to addr 4 -> write dropped, ready=0 next cycle, busy all 0.
  - After 24 cycles, addr 4 reads 0.
